// File: rtl/serial_frame_decoder.sv
// Deserializes start/8-data/[parity]/stop frames, decodes (reverse+invert) into a show-ahead FIFO; parity stage enabled by SERIAL_FRAME_DECODER_PARITY_EN.
// Byte visible the cycle after its stop-bit edge; dec_valid/dec_ready pops, pushes into a full FIFO without a same-cycle pop are dropped.
module serial_frame_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ser_valid,
  input  logic                          ser_bit,
  output logic [7:0]                    dec_data,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic                          parity_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [7:0]   sh_q, sh_d;
  logic [7:0]   dec_byte;
  logic         push_req, par_bad;
  logic         frame_err_q, frame_err_d;
  logic         overflow_q, overflow_d;

  logic [7:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic         full, pop, push;

`ifdef SERIAL_FRAME_DECODER_PARITY_EN
  logic par_q, par_d;
  logic parity_err_q, parity_err_d;
  // enc bits plus parity bit must hold an odd number of ones
  assign par_bad = ~(^{sh_q, par_q});
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
`ifdef SERIAL_FRAME_DECODER_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    if (ser_valid) begin
      case (state_q)
        S_IDLE: begin
          if (!ser_bit) begin
            state_d = S_DATA;
            cnt_d   = 3'd0;
          end
        end
        S_DATA: begin
          sh_d  = {ser_bit, sh_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
`ifdef SERIAL_FRAME_DECODER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
        S_PARITY: begin
`ifdef SERIAL_FRAME_DECODER_PARITY_EN
          par_d = ser_bit;
`endif
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d     = S_IDLE;
          frame_err_d = ~ser_bit;
          push_req    = ser_bit & ~par_bad;
`ifdef SERIAL_FRAME_DECODER_PARITY_EN
          parity_err_d = par_bad;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    dec_byte = 8'h00;
    for (int i = 0; i < 8; i++) dec_byte[i] = ~sh_q[7-i];
  end

  assign dec_valid  = (count_q != '0);
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign pop        = dec_valid & dec_ready;
  assign push       = push_req & (~full | pop);
  assign overflow_d = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      sh_q        <= 8'h00;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= dec_byte;
  end

`ifdef SERIAL_FRAME_DECODER_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // Gate the head so an empty FIFO presents zero rather than stale storage
  assign dec_data   = dec_valid ? mem_q[rd_q] : 8'h00;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule
